// File: rtl/alu_unit_if.sv
// Operand/opcode and result/flag bundle between the register-file read buses and the ALU.
interface alu_unit_if;
   logic [31:0] bus_A;
   logic [31:0] bus_B;
   logic [4:0]  instruction;
   logic [31:0] out_bus;
   logic        Z;
   logic        N;
   logic        C;
   logic        V;

   modport master (
      output bus_A, bus_B, instruction,
      input  out_bus, Z, N, C, V
   );

   modport slave (
      input  bus_A, bus_B, instruction,
      output out_bus, Z, N, C, V
   );
endinterface

// File: rtl/alu_unit.sv
// 32-bit combinational ALU with Z/N/C/V flags; undefined opcodes replay the
// result captured in a clocked hold register.
module alu_unit (
   input  logic       clk,
   input  logic       reset,
   alu_unit_if.slave  io
);
   localparam int unsigned W = 32;

   localparam logic [4:0] OP_LD  = 5'h01;
   localparam logic [4:0] OP_ADD = 5'h03;
   localparam logic [4:0] OP_SUB = 5'h04;
   localparam logic [4:0] OP_AND = 5'h05;
   localparam logic [4:0] OP_OR  = 5'h06;
   localparam logic [4:0] OP_XOR = 5'h07;
   localparam logic [4:0] OP_NOT = 5'h08;
   localparam logic [4:0] OP_SL  = 5'h09;
   localparam logic [4:0] OP_SR  = 5'h0A;

   typedef struct packed {
      logic [W-1:0] r;
      logic         z;
      logic         n;
      logic         c;
      logic         v;
   } res_t;

   res_t         alu_c;
   res_t         out_c;
   res_t         hold;
   logic [W:0]   sum_c;
   logic         valid_c;

   // Opcode decode and datapath; valid_c clear selects the hold register.
   always_comb begin
      alu_c   = '0;
      sum_c   = '0;
      valid_c = 1'b1;
      case (io.instruction)
         OP_LD:  alu_c.r = io.bus_A;
         OP_ADD: begin
            sum_c   = {1'b0, io.bus_A} + {1'b0, io.bus_B};
            alu_c.r = sum_c[W-1:0];
            alu_c.c = sum_c[W];
            alu_c.v = (io.bus_A[W-1] == io.bus_B[W-1]) && (sum_c[W-1] != io.bus_A[W-1]);
         end
         OP_SUB: begin
            sum_c   = {1'b0, io.bus_A} + {1'b0, ~io.bus_B} + (W+1)'(1);
            alu_c.r = sum_c[W-1:0];
            alu_c.c = sum_c[W];
            alu_c.v = (io.bus_A[W-1] != io.bus_B[W-1]) && (sum_c[W-1] != io.bus_A[W-1]);
         end
         OP_AND: alu_c.r = io.bus_A & io.bus_B;
         OP_OR:  alu_c.r = io.bus_A | io.bus_B;
         OP_XOR: alu_c.r = io.bus_A ^ io.bus_B;
         OP_NOT: alu_c.r = ~io.bus_A;
         OP_SL: begin
            alu_c.r = {io.bus_A[W-2:0], 1'b0};
            alu_c.c = io.bus_A[W-1];
         end
         OP_SR: begin
            alu_c.r = {1'b0, io.bus_A[W-1:1]};
            alu_c.c = io.bus_A[0];
         end
         default: valid_c = 1'b0;
      endcase
      alu_c.z = (alu_c.r == '0);
      alu_c.n = alu_c.r[W-1];
   end

   // Reset forces zero asynchronously; otherwise live result or held value.
   always_comb begin
      out_c = hold;
      if (!reset) begin
         out_c = '0;
      end else if (valid_c) begin
         out_c = alu_c;
      end
   end

   // Under a hold opcode out_c equals hold, so an unconditional load is a no-op.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold <= '0;
      end else begin
         hold <= out_c;
      end
   end

   assign io.out_bus = out_c.r;
   assign io.Z       = out_c.z;
   assign io.N       = out_c.n;
   assign io.C       = out_c.c;
   assign io.V       = out_c.v;
endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: hand-computed results and ZNCV flags per opcode,
// plus hold-register and asynchronous-reset behaviour.
module tb_alu_unit;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   alu_unit_if bus ();

   alu_unit dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change just after a falling edge, far from the rising edge.
   task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.instruction = op;
      bus.bus_A       = a;
      bus.bus_B       = b;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] exp_r, input logic [3:0] exp_zncv);
      logic [35:0] obs;
      logic [35:0] exp;
      obs = {bus.out_bus, bus.Z, bus.N, bus.C, bus.V};
      exp = {exp_r, exp_zncv};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed out=%h zncv=%b expected out=%h zncv=%b",
                tag, obs[35:4], obs[3:0], exp[35:4], exp[3:0]);
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b0;
      bus.instruction = 5'h03;
      bus.bus_A       = 32'd1;
      bus.bus_B       = 32'd2;
      #2;
      check("reset_forces_zero", 32'h0, 4'b0000);

      @(negedge clk);
      reset           = 1'b1;
      bus.instruction = 5'h00;
      #1;
      check("hold_after_reset", 32'h0, 4'b0000);

      apply(5'h01, 32'd12345, 32'd0);
      check("ld", 32'd12345, 4'b0000);
      apply(5'h03, 32'd12345, 32'd54321);
      check("add_plain", 32'd66666, 4'b0000);
      apply(5'h03, 32'hFFFF_FFFF, 32'd1);
      check("add_wrap_zero", 32'h0, 4'b1010);
      apply(5'h03, 32'hFFFF_FFFF, 32'h8000_0000);
      check("add_overflow", 32'h7FFF_FFFF, 4'b0011);
      apply(5'h04, 32'd10000, 32'd10000);
      check("sub_equal", 32'h0, 4'b1010);
      apply(5'h04, 32'h8000_0000, 32'd1);
      check("sub_overflow", 32'h7FFF_FFFF, 4'b0011);
      apply(5'h04, 32'd1, 32'd2);
      check("sub_borrow", 32'hFFFF_FFFF, 4'b0100);
      apply(5'h05, 32'hAAAA_AAAA, 32'hFFFF_0000);
      check("and", 32'hAAAA_0000, 4'b0100);
      apply(5'h06, 32'hAAAA_AAAA, 32'hFFFF_0000);
      check("or", 32'hFFFF_AAAA, 4'b0100);
      apply(5'h07, 32'hAAAA_AAAA, 32'hFFFF_0000);
      check("xor", 32'h5555_AAAA, 4'b0000);
      apply(5'h08, 32'hAAAA_AAAA, 32'hFFFF_0000);
      check("not", 32'h5555_5555, 4'b0000);
      apply(5'h09, 32'hAAAA_AAAA, 32'h0);
      check("sl", 32'h5555_5554, 4'b0010);
      apply(5'h0A, 32'hAAAA_AAAA, 32'h0);
      check("sr", 32'h5555_5555, 4'b0000);
      apply(5'h0A, 32'h0000_0001, 32'h0);
      check("sr_to_zero", 32'h0, 4'b1010);

      // Capture 1+2 on a rising edge, then hold it under undefined opcodes.
      apply(5'h03, 32'd1, 32'd2);
      check("add_1_2", 32'd3, 4'b0000);
      apply(5'h00, 32'h1234_5678, 32'h9ABC_DEF0);
      check("hold_op00", 32'd3, 4'b0000);
      apply(5'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("hold_op02", 32'd3, 4'b0000);
      apply(5'h0B, 32'h8000_0000, 32'h1);
      check("hold_op0b", 32'd3, 4'b0000);
      apply(5'h1F, 32'h0, 32'h0);
      check("hold_op1f", 32'd3, 4'b0000);

      // Reset between edges drops outputs without waiting for a clock.
      reset = 1'b0;
      #1;
      check("reset_mid_hold", 32'h0, 4'b0000);
      apply(5'h03, 32'd5, 32'd6);
      check("reset_forces_add", 32'h0, 4'b0000);
      @(negedge clk);
      bus.instruction = 5'h00;
      reset           = 1'b1;
      #1;
      check("release_hold_zero", 32'h0, 4'b0000);
      apply(5'h00, 32'd7, 32'd8);
      check("release_after_edge", 32'h0, 4'b0000);

      // Normal operation resumes and the hold register reloads.
      apply(5'h03, 32'd5, 32'd6);
      check("add_after_reset", 32'd11, 4'b0000);
      apply(5'h00, 32'd0, 32'd0);
      check("hold_after_reset_add", 32'd11, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
